// File: rtl/instr_encoder_if.sv
// Bundle/memory-side signal group for the RV32I instruction encoder.
// The slave modport is the encoder's view; master is the producer/memory side.
interface instr_encoder_if #(
    parameter int ADDR_W = 10
);
    logic              in_valid;
    logic              in_ready;
    logic [1:0]        in_fmt;
    logic [4:0]        in_rs1;
    logic [4:0]        in_rs2;
    logic [4:0]        in_rd;
    logic [2:0]        in_funct3;
    logic [11:0]       in_imm;
    logic [6:0]        in_funct7;
    logic              flush;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              mem_ack;
    logic              err_illegal;
    logic [7:0]        illegal_cnt;
    logic              wrapped;

    modport master (
        output in_valid, in_fmt, in_rs1, in_rs2, in_rd, in_funct3, in_imm, in_funct7,
        output flush, mem_ack,
        input  in_ready, mem_we, mem_addr, mem_wdata, err_illegal, illegal_cnt, wrapped
    );

    modport slave (
        input  in_valid, in_fmt, in_rs1, in_rs2, in_rd, in_funct3, in_imm, in_funct7,
        input  flush, mem_ack,
        output in_ready, mem_we, mem_addr, mem_wdata, err_illegal, illegal_cnt, wrapped
    );
endinterface

// File: rtl/instr_encoder.sv
// RV32I field-to-word encoder: packs LOAD/OP-IMM/STORE/OP bundles, rejects illegal
// combinations, and streams words through a small FIFO into instruction memory.
module instr_encoder #(
    parameter int unsigned ADDR_W     = 10,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned BASE_ADDR  = 0
) (
    input  logic            clk,
    input  logic            rst_n,
    instr_encoder_if.slave  bus
);
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    localparam int unsigned       PTR_W      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned       CNT_W      = PTR_W + 1;
    localparam logic [CNT_W-1:0]  DEPTH_C    = CNT_W'(FIFO_DEPTH);
    localparam logic [ADDR_W-1:0] BASE_C     = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] ADDR_MAX_C = {ADDR_W{1'b1}};

    function automatic logic [31:0] encode(
        input logic [1:0]  fmt,
        input logic [4:0]  rs1,
        input logic [4:0]  rs2,
        input logic [4:0]  rd,
        input logic [2:0]  f3,
        input logic [11:0] imm,
        input logic [6:0]  f7
    );
        logic [31:0] word;
        case (fmt)
            2'b00:   word = {imm, rs1, f3, rd, 7'b0000011};
            2'b01:   word = {imm, rs1, f3, rd, 7'b0010011};
            2'b10:   word = {imm[11:5], rs2, rs1, f3, imm[4:0], 7'b0100011};
            2'b11:   word = {f7, rs2, rs1, f3, rd, 7'b0110011};
            default: word = 32'h0000_0000;
        endcase
        return word;
    endfunction

    function automatic logic is_legal(
        input logic [1:0]  fmt,
        input logic [2:0]  f3,
        input logic [11:0] imm,
        input logic [6:0]  f7
    );
        logic ok;
        case (fmt)
            2'b00: ok = !((f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111));
            2'b01: begin
                // Shift immediates reuse imm[11:5] as a funct7-like selector.
                if (f3 == 3'b001) begin
                    ok = (imm[11:5] == 7'b0000000);
                end else if (f3 == 3'b101) begin
                    ok = (imm[11:5] == 7'b0000000) || (imm[11:5] == 7'b0100000);
                end else begin
                    ok = 1'b1;
                end
            end
            2'b10: ok = (f3 <= 3'b010);
            2'b11: begin
                if (f7 == 7'b0000000) begin
                    ok = 1'b1;
                end else if (f7 == 7'b0100000) begin
                    ok = (f3 == 3'b000) || (f3 == 3'b101);
                end else begin
                    ok = 1'b0;
                end
            end
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    logic [31:0]       fifo_mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_r;
    logic [PTR_W-1:0]  rd_ptr_r;
    logic [CNT_W-1:0]  count_r;

    state_t            state_r;
    state_t            state_s;
    logic              mem_we_r;
    logic              mem_we_s;
    logic [ADDR_W-1:0] addr_r;
    logic [ADDR_W-1:0] addr_s;
    logic [31:0]       wdata_r;
    logic [31:0]       wdata_s;
    logic              wrapped_r;
    logic              wrapped_s;
    logic              err_r;
    logic [7:0]        illegal_cnt_r;

    logic              in_ready_s;
    logic              accept_s;
    logic              legal_s;
    logic              push_s;
    logic              pop_s;
    logic              fifo_empty_s;
    logic [31:0]       enc_s;

    assign enc_s        = encode(bus.in_fmt, bus.in_rs1, bus.in_rs2, bus.in_rd,
                                 bus.in_funct3, bus.in_imm, bus.in_funct7);
    assign legal_s      = is_legal(bus.in_fmt, bus.in_funct3, bus.in_imm, bus.in_funct7);
    // No credit is taken for a same-cycle pop: readiness depends only on stored count.
    assign in_ready_s   = rst_n && (count_r < DEPTH_C) && !bus.flush;
    assign accept_s     = bus.in_valid && in_ready_s;
    assign push_s       = accept_s && legal_s;
    assign fifo_empty_s = (count_r == '0);

    // FIFO storage: written only on a legal accepted bundle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                fifo_mem_r[i] <= 32'h0000_0000;
            end
        end else if (push_s) begin
            fifo_mem_r[wr_ptr_r] <= enc_s;
        end
    end

    // FIFO pointers and occupancy; flush discards all stored words.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else if (bus.flush) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Writer next-state and output-register values; flush overrides ack.
    always_comb begin
        state_s   = state_r;
        mem_we_s  = mem_we_r;
        addr_s    = addr_r;
        wdata_s   = wdata_r;
        wrapped_s = wrapped_r;
        pop_s     = 1'b0;
        if (bus.flush) begin
            state_s   = ST_IDLE;
            mem_we_s  = 1'b0;
            addr_s    = BASE_C;
            wrapped_s = 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (!fifo_empty_s) begin
                        pop_s    = 1'b1;
                        wdata_s  = fifo_mem_r[rd_ptr_r];
                        mem_we_s = 1'b1;
                        state_s  = ST_BUSY;
                    end else begin
                        mem_we_s = 1'b0;
                    end
                end
                ST_BUSY: begin
                    if (bus.mem_ack) begin
                        addr_s = addr_r + ADDR_W'(1);
                        if (addr_r == ADDR_MAX_C) begin
                            wrapped_s = 1'b1;
                        end else begin
                            wrapped_s = wrapped_r;
                        end
                        if (!fifo_empty_s) begin
                            pop_s    = 1'b1;
                            wdata_s  = fifo_mem_r[rd_ptr_r];
                            mem_we_s = 1'b1;
                        end else begin
                            mem_we_s = 1'b0;
                            state_s  = ST_IDLE;
                        end
                    end else begin
                        mem_we_s = 1'b1;
                    end
                end
                default: begin
                    state_s  = ST_IDLE;
                    mem_we_s = 1'b0;
                end
            endcase
        end
    end

    // Writer state and registered memory-side outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            mem_we_r  <= 1'b0;
            addr_r    <= BASE_C;
            wdata_r   <= 32'h0000_0000;
            wrapped_r <= 1'b0;
        end else begin
            state_r   <= state_s;
            mem_we_r  <= mem_we_s;
            addr_r    <= addr_s;
            wdata_r   <= wdata_s;
            wrapped_r <= wrapped_s;
        end
    end

    // Rejection pulse and saturating reject counter; flush leaves the count alone.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_r         <= 1'b0;
            illegal_cnt_r <= 8'd0;
        end else begin
            err_r <= accept_s && !legal_s;
            if (accept_s && !legal_s && (illegal_cnt_r != 8'hFF)) begin
                illegal_cnt_r <= illegal_cnt_r + 8'd1;
            end
        end
    end

    assign bus.in_ready    = in_ready_s;
    assign bus.mem_we      = mem_we_r;
    assign bus.mem_addr    = addr_r;
    assign bus.mem_wdata   = wdata_r;
    assign bus.err_illegal = err_r;
    assign bus.illegal_cnt = illegal_cnt_r;
    assign bus.wrapped     = wrapped_r;

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder: a 10-bit-address instance plus a 2-bit-address
// twin fed the same stimulus to exercise address wrap.
module tb_instr_encoder;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    instr_encoder_if #(.ADDR_W(10)) bm ();
    instr_encoder_if #(.ADDR_W(2))  bw ();

    instr_encoder #(.ADDR_W(10), .FIFO_DEPTH(4), .BASE_ADDR(0)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bm.slave));
    instr_encoder #(.ADDR_W(2), .FIFO_DEPTH(4), .BASE_ADDR(0)) dut_w (
        .clk(clk), .rst_n(rst_n), .bus(bw.slave));

    assign bw.in_valid  = bm.in_valid;
    assign bw.in_fmt    = bm.in_fmt;
    assign bw.in_rs1    = bm.in_rs1;
    assign bw.in_rs2    = bm.in_rs2;
    assign bw.in_rd     = bm.in_rd;
    assign bw.in_funct3 = bm.in_funct3;
    assign bw.in_imm    = bm.in_imm;
    assign bw.in_funct7 = bm.in_funct7;
    assign bw.flush     = bm.flush;
    assign bw.mem_ack   = bm.mem_ack;

    typedef struct {
        logic [9:0]  addr;
        logic [31:0] data;
    } sb_t;

    sb_t         sb[$];
    sb_t         mon_e;
    int          checks = 0;
    int          passed = 0;
    int          cycle = 0;
    int          exp_illegal = 0;
    logic [9:0]  exp_addr = 10'd0;
    logic        wrapped_exp = 1'b0;
    bit          mon_en = 1'b0;
    int          wr_cycles[$];
    logic [31:0] wr_data[$];
    logic [9:0]  wr_addr[$];
    logic [1:0]  wr_addr_w[$];

    always @(posedge clk) cycle <= cycle + 1;

    function automatic logic [31:0] model_enc(input logic [1:0] fmt, input logic [4:0] rs1,
        input logic [4:0] rs2, input logic [4:0] rd, input logic [2:0] f3,
        input logic [11:0] imm, input logic [6:0] f7);
        logic [31:0] w;
        logic [31:0] i32;
        i32 = {20'd0, imm};
        w = (32'(rs1) << 15) | (32'(f3) << 12);
        case (fmt)
            2'd0:    w = w | (i32 << 20) | (32'(rd) << 7) | 32'h03;
            2'd1:    w = w | (i32 << 20) | (32'(rd) << 7) | 32'h13;
            2'd2:    w = w | ((i32 >> 5) << 25) | (32'(rs2) << 20) | ((i32 & 32'h1F) << 7) | 32'h23;
            default: w = w | (32'(f7) << 25) | (32'(rs2) << 20) | (32'(rd) << 7) | 32'h33;
        endcase
        return w;
    endfunction

    function automatic bit model_legal(input logic [1:0] fmt, input logic [2:0] f3,
        input logic [11:0] imm, input logic [6:0] f7);
        int f;
        int hi;
        f  = int'(f3);
        hi = int'(imm) / 32;
        case (fmt)
            2'd0: return !(f == 3 || f == 6 || f == 7);
            2'd1: begin
                if (f == 1) return hi == 0;
                if (f == 5) return (hi == 0) || (hi == 32);
                return 1'b1;
            end
            2'd2: return f <= 2;
            default: begin
                if (int'(f7) == 0) return 1'b1;
                if (int'(f7) == 32) return (f == 0) || (f == 5);
                return 1'b0;
            end
        endcase
    endfunction

    // Memory-side monitor: every completed write is popped against the scoreboard.
    always @(negedge clk) begin
        if (mon_en && rst_n) begin
            if (bm.mem_we && bm.mem_ack && !bm.flush) begin
                checks++;
                if (sb.size() == 0) begin
                    $display("FAIL unexpected_write: addr=%0d data=%08h with nothing expected",
                             bm.mem_addr, bm.mem_wdata);
                end else begin
                    mon_e = sb.pop_front();
                    if (bm.mem_wdata !== mon_e.data || bm.mem_addr !== mon_e.addr)
                        $display("FAIL write: got addr=%0d data=%08h, expected addr=%0d data=%08h",
                                 bm.mem_addr, bm.mem_wdata, mon_e.addr, mon_e.data);
                    else passed++;
                    checks++;
                    if (bw.mem_we !== 1'b1 || bw.mem_addr !== mon_e.addr[1:0])
                        $display("FAIL wrap_inst_write: got we=%b addr=%0d, expected we=1 addr=%0d",
                                 bw.mem_we, bw.mem_addr, mon_e.addr[1:0]);
                    else passed++;
                    wr_cycles.push_back(cycle);
                    wr_data.push_back(bm.mem_wdata);
                    wr_addr.push_back(bm.mem_addr);
                    wr_addr_w.push_back(bw.mem_addr);
                end
            end
            checks++;
            if (bw.wrapped !== wrapped_exp)
                $display("FAIL wrapped_flag: got %b, expected %b", bw.wrapped, wrapped_exp);
            else passed++;
            if (bm.mem_we && bm.mem_ack && !bm.flush && bw.mem_addr == 2'd3) wrapped_exp = 1'b1;
            if (bm.flush) wrapped_exp = 1'b0;
        end
    end

    task automatic send(input logic [1:0] fmt, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [4:0] rd, input logic [2:0] f3, input logic [11:0] imm,
                        input logic [6:0] f7);
        bit done;
        done = 1'b0;
        bm.in_fmt = fmt; bm.in_rs1 = rs1; bm.in_rs2 = rs2; bm.in_rd = rd;
        bm.in_funct3 = f3; bm.in_imm = imm; bm.in_funct7 = f7; bm.in_valid = 1'b1;
        for (int k = 0; k < 40 && !done; k++) begin
            @(negedge clk);
            if (bm.in_ready) begin
                done = 1'b1;
                if (model_legal(fmt, f3, imm, f7)) begin
                    sb.push_back('{exp_addr, model_enc(fmt, rs1, rs2, rd, f3, imm, f7)});
                    exp_addr++;
                end else if (exp_illegal < 255) begin
                    exp_illegal++;
                end
            end
            @(posedge clk); #1;
        end
        bm.in_valid = 1'b0;
        checks++;
        if (!done) $display("FAIL send_timeout: in_ready never seen high, got 0 expected 1");
        else passed++;
    endtask

    task automatic wait_drain();
        for (int k = 0; k < 60; k++) begin
            @(negedge clk); #1;
            if (sb.size() == 0 && !bm.mem_we) break;
        end
        checks++;
        if (sb.size() != 0 || bm.mem_we !== 1'b0)
            $display("FAIL drain: %0d words still expected, mem_we=%b, expected 0 and 0",
                     sb.size(), bm.mem_we);
        else passed++;
        @(posedge clk); #1;
    endtask

    task automatic do_flush();
        bm.flush = 1'b1;
        @(negedge clk);
        checks++;
        if (bm.in_ready !== 1'b0) $display("FAIL flush_ready: got %b expected 0", bm.in_ready);
        else passed++;
        @(posedge clk); #1;
        bm.flush = 1'b0;
        sb.delete();
        exp_addr = 10'd0;
        checks++;
        if (bm.mem_we !== 1'b0 || bm.mem_addr !== 10'd0)
            $display("FAIL flush_state: got we=%b addr=%0d expected we=0 addr=0", bm.mem_we, bm.mem_addr);
        else passed++;
    endtask

    task automatic test_reset();
        checks++;
        if (bm.mem_we !== 1'b0 || bm.mem_addr !== 10'd0 || bm.mem_wdata !== 32'd0 ||
            bm.err_illegal !== 1'b0 || bm.illegal_cnt !== 8'd0 || bm.wrapped !== 1'b0 ||
            bm.in_ready !== 1'b0)
            $display("FAIL reset_state: we=%b addr=%0d data=%08h err=%b cnt=%0d wrap=%b rdy=%b, expected all 0",
                     bm.mem_we, bm.mem_addr, bm.mem_wdata, bm.err_illegal, bm.illegal_cnt,
                     bm.wrapped, bm.in_ready);
        else passed++;
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (bm.in_ready !== 1'b1) $display("FAIL ready_after_reset: got %b expected 1", bm.in_ready);
        else passed++;
        @(posedge clk); #1;
        mon_en = 1'b1;
    endtask

    task automatic test_single_opimm();
        bm.mem_ack = 1'b1;
        send(2'd1, 5'd0, 5'd0, 5'd1, 3'd0, 12'd5, 7'd0);
        @(negedge clk);
        checks++;
        if (bm.mem_we !== 1'b0) $display("FAIL no_bypass: mem_we=%b expected 0", bm.mem_we);
        else passed++;
        @(negedge clk);
        checks++;
        if (bm.mem_we !== 1'b1 || bm.mem_addr !== 10'd0 || bm.mem_wdata !== 32'h0050_0093)
            $display("FAIL opimm_write: we=%b addr=%0d data=%08h expected we=1 addr=0 data=00500093",
                     bm.mem_we, bm.mem_addr, bm.mem_wdata);
        else passed++;
        @(negedge clk);
        checks++;
        if (bm.mem_we !== 1'b0 || bm.mem_addr !== 10'd1)
            $display("FAIL opimm_after: we=%b addr=%0d expected we=0 addr=1", bm.mem_we, bm.mem_addr);
        else passed++;
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        do_flush();
        wr_cycles.delete(); wr_data.delete(); wr_addr.delete();
        bm.mem_ack = 1'b1;
        send(2'd0, 5'd1, 5'd0, 5'd2, 3'd2, 12'd8, 7'd0);
        send(2'd2, 5'd1, 5'd2, 5'd0, 3'd2, 12'd12, 7'd0);
        send(2'd3, 5'd1, 5'd2, 5'd3, 3'd0, 12'd0, 7'h20);
        wait_drain();
        checks++;
        if (wr_data.size() != 3) $display("FAIL b2b_count: got %0d writes expected 3", wr_data.size());
        else begin
            if (wr_data[0] !== 32'h0080_A103 || wr_data[1] !== 32'h0020_A623 || wr_data[2] !== 32'h4020_81B3 ||
                wr_addr[0] !== 10'd0 || wr_addr[1] !== 10'd1 || wr_addr[2] !== 10'd2)
                $display("FAIL b2b_words: got %08h@%0d %08h@%0d %08h@%0d expected 0080a103@0 0020a623@1 402081b3@2",
                         wr_data[0], wr_addr[0], wr_data[1], wr_addr[1], wr_data[2], wr_addr[2]);
            else if (wr_cycles[1] != wr_cycles[0] + 1 || wr_cycles[2] != wr_cycles[1] + 1)
                $display("FAIL b2b_timing: write cycles %0d %0d %0d expected consecutive",
                         wr_cycles[0], wr_cycles[1], wr_cycles[2]);
            else passed++;
        end
    endtask

    task automatic test_backpressure();
        int acc;
        logic [31:0] first;
        do_flush();
        wr_data.delete(); wr_addr.delete();
        bm.mem_ack = 1'b0;
        acc = 0;
        first = model_enc(2'd1, 5'd3, 5'd0, 5'd1, 3'd0, 12'd0, 7'd0);
        for (int c = 0; c < 10; c++) begin
            bm.in_fmt = 2'd1; bm.in_rs1 = 5'd3; bm.in_rd = 5'(acc + 1); bm.in_funct3 = 3'd0;
            bm.in_imm = 12'(acc * 3); bm.in_rs2 = 5'd0; bm.in_funct7 = 7'd0; bm.in_valid = 1'b1;
            @(negedge clk);
            if (bm.in_ready) begin
                sb.push_back('{exp_addr, model_enc(2'd1, 5'd3, 5'd0, 5'(acc + 1), 3'd0, 12'(acc * 3), 7'd0)});
                exp_addr++;
                acc++;
            end
            @(posedge clk); #1;
        end
        bm.in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (acc != 5 || bm.in_ready !== 1'b0)
            $display("FAIL capacity: accepted %0d ready=%b expected 5 and 0", acc, bm.in_ready);
        else passed++;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if (bm.mem_we !== 1'b1 || bm.mem_addr !== 10'd0 || bm.mem_wdata !== first)
                $display("FAIL hold_stable: we=%b addr=%0d data=%08h expected we=1 addr=0 data=%08h",
                         bm.mem_we, bm.mem_addr, bm.mem_wdata, first);
            else passed++;
        end
        @(posedge clk); #1;
        bm.mem_ack = 1'b1;
        wait_drain();
        checks++;
        if (wr_addr.size() != 5 || wr_addr[4] !== 10'd4)
            $display("FAIL bp_writes: got %0d writes expected 5 ending at addr 4", wr_addr.size());
        else passed++;
    endtask

    task automatic test_illegal();
        logic [1:0]  t_fmt [6] = '{2'd2, 2'd1, 2'd1, 2'd1, 2'd3, 2'd3};
        logic [2:0]  t_f3  [6] = '{3'd3, 3'd1, 3'd5, 3'd5, 3'd1, 3'd5};
        logic [11:0] t_imm [6] = '{12'd4, 12'h020, 12'h400, 12'h7E0, 12'd0, 12'd0};
        logic [6:0]  t_f7  [6] = '{7'd0, 7'd0, 7'd0, 7'd0, 7'h20, 7'h20};
        do_flush();
        wr_addr.delete();
        bm.mem_ack = 1'b1;
        send(2'd3, 5'd1, 5'd2, 5'd3, 3'd0, 12'd0, 7'd1);
        @(negedge clk);
        checks++;
        if (bm.err_illegal !== 1'b1 || bm.mem_we !== 1'b0)
            $display("FAIL illegal_op: err=%b we=%b expected err=1 we=0", bm.err_illegal, bm.mem_we);
        else passed++;
        @(posedge clk); #1;
        send(2'd0, 5'd1, 5'd0, 5'd2, 3'd7, 12'd0, 7'd0);
        @(negedge clk);
        checks++;
        if (bm.err_illegal !== 1'b1 || bm.illegal_cnt !== 8'd2 || bm.mem_we !== 1'b0)
            $display("FAIL illegal_load: err=%b cnt=%0d we=%b expected 1, 2, 0",
                     bm.err_illegal, bm.illegal_cnt, bm.mem_we);
        else passed++;
        @(negedge clk);
        checks++;
        if (bm.err_illegal !== 1'b0) $display("FAIL err_pulse: err=%b expected 0", bm.err_illegal);
        else passed++;
        @(posedge clk); #1;
        send(2'd1, 5'd4, 5'd0, 5'd5, 3'd4, 12'hABC, 7'd0);
        wait_drain();
        checks++;
        if (wr_addr.size() != 1 || wr_addr[0] !== 10'd0)
            $display("FAIL legal_after_illegal: %0d writes expected one at addr 0", wr_addr.size());
        else passed++;
        for (int i = 0; i < 6; i++) send(t_fmt[i], 5'd6, 5'd7, 5'd8, t_f3[i], t_imm[i], t_f7[i]);
        wait_drain();
        checks++;
        if (bm.illegal_cnt !== 8'(exp_illegal))
            $display("FAIL illegal_table: cnt=%0d expected %0d", bm.illegal_cnt, exp_illegal);
        else passed++;
    endtask

    task automatic test_wrap();
        do_flush();
        wr_addr_w.delete();
        bm.mem_ack = 1'b1;
        for (int i = 0; i < 5; i++) send(2'd1, 5'(i), 5'd0, 5'(i + 9), 3'd0, 12'(i + 100), 7'd0);
        wait_drain();
        checks++;
        if (wr_addr_w.size() != 5 || wr_addr_w[0] !== 2'd0 || wr_addr_w[1] !== 2'd1 ||
            wr_addr_w[2] !== 2'd2 || wr_addr_w[3] !== 2'd3 || wr_addr_w[4] !== 2'd0 || bw.wrapped !== 1'b1)
            $display("FAIL wrap_seq: %0d writes wrapped=%b expected addrs 0,1,2,3,0 and wrapped=1",
                     wr_addr_w.size(), bw.wrapped);
        else passed++;
        do_flush();
        checks++;
        if (bw.wrapped !== 1'b0 || bw.mem_addr !== 2'd0)
            $display("FAIL wrap_flush: wrapped=%b addr=%0d expected 0 and 0", bw.wrapped, bw.mem_addr);
        else passed++;
    endtask

    task automatic test_flush_mid();
        do_flush();
        wr_addr.delete();
        bm.mem_ack = 1'b0;
        for (int i = 0; i < 3; i++) send(2'd3, 5'(i), 5'd2, 5'd3, 3'd0, 12'd0, 7'd0);
        @(negedge clk);
        checks++;
        if (bm.mem_we !== 1'b1) $display("FAIL pending_write: we=%b expected 1", bm.mem_we);
        else passed++;
        @(posedge clk); #1;
        bm.mem_ack = 1'b1;
        do_flush();
        bm.mem_ack = 1'b0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            checks++;
            if (bm.mem_we !== 1'b0 || bm.mem_addr !== 10'd0 || bm.in_ready !== 1'b1)
                $display("FAIL after_flush: we=%b addr=%0d rdy=%b expected 0, 0, 1",
                         bm.mem_we, bm.mem_addr, bm.in_ready);
            else passed++;
        end
        @(posedge clk); #1;
        bm.mem_ack = 1'b1;
        send(2'd0, 5'd1, 5'd0, 5'd2, 3'd4, 12'd16, 7'd0);
        wait_drain();
        checks++;
        if (wr_addr.size() != 1 || wr_addr[0] !== 10'd0)
            $display("FAIL post_flush_write: %0d writes expected one at addr 0", wr_addr.size());
        else passed++;
    endtask

    task automatic test_reset_mid();
        wr_addr.delete();
        bm.mem_ack = 1'b0;
        send(2'd1, 5'd1, 5'd0, 5'd1, 3'd0, 12'd1, 7'd0);
        send(2'd1, 5'd1, 5'd0, 5'd1, 3'd0, 12'd2, 7'd0);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (bm.mem_we !== 1'b0 || bm.mem_addr !== 10'd0 || bm.mem_wdata !== 32'd0 ||
            bm.in_ready !== 1'b0 || bm.illegal_cnt !== 8'd0)
            $display("FAIL mid_reset: we=%b addr=%0d data=%08h rdy=%b cnt=%0d expected all 0",
                     bm.mem_we, bm.mem_addr, bm.mem_wdata, bm.in_ready, bm.illegal_cnt);
        else passed++;
        sb.delete(); exp_addr = 10'd0; exp_illegal = 0; wrapped_exp = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        bm.mem_ack = 1'b1;
        send(2'd2, 5'd3, 5'd4, 5'd0, 3'd1, 12'h7FF, 7'd0);
        wait_drain();
        checks++;
        if (wr_addr.size() != 1 || wr_addr[0] !== 10'd0)
            $display("FAIL post_reset_write: %0d writes expected one at addr 0", wr_addr.size());
        else passed++;
    endtask

    initial begin
        rst_n = 1'b0;
        bm.in_valid = 1'b0; bm.in_fmt = 2'd0; bm.in_rs1 = 5'd0; bm.in_rs2 = 5'd0; bm.in_rd = 5'd0;
        bm.in_funct3 = 3'd0; bm.in_imm = 12'd0; bm.in_funct7 = 7'd0; bm.flush = 1'b0; bm.mem_ack = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        test_single_opimm();
        test_back_to_back();
        test_backpressure();
        test_illegal();
        test_wrap();
        test_flush_mid();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
- RV32I instruction encoder: the write-side counterpart of the pipeline's field decoder.
- Accepts instruction fields (format, rs1, rs2, rd, funct3, imm, funct7) over a valid/ready handshake and packs them into 32-bit RV32I words.
- Rejects illegal field combinations.
- Buffers encoded words in a small FIFO and streams them into instruction memory at auto-incrementing addresses; used by the boot loader and self-test program generator.

Parameters:
- ADDR_W, 10, instruction-memory word-address width
- FIFO_DEPTH, 4, encoded-word FIFO entries (power of 2, ≥2)
- BASE_ADDR, 0, first write address after reset/flush

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  field bundle valid
- in_ready  out  1  encoder can accept bundle
- in_fmt  in  2  00 LOAD, 01 OP-IMM, 10 STORE, 11 OP
- in_rs1  in  5  source register 1
- in_rs2  in  5  source register 2 (STORE, OP)
- in_rd  in  5  destination register (LOAD, OP-IMM, OP)
- in_funct3  in  3  funct3 / width field
- in_imm  in  12  immediate (LOAD, OP-IMM, STORE)
- in_funct7  in  7  funct7 (OP only)
- flush  in  1  synchronous clear of FIFO, pending write and address
- mem_we  out  1  memory write request
- mem_addr  out  ADDR_W  word address
- mem_wdata  out  32  encoded instruction
- mem_ack  in  1  memory accepted current write
- err_illegal  out  1  one-cycle pulse: bundle rejected
- illegal_cnt  out  8  saturating count of rejected bundles
- wrapped  out  1  sticky: address wrapped past 2^ADDR_W-1

Behaviour:
- Reset (rst_n low, async): mem_we=0, mem_addr=BASE_ADDR, mem_wdata=0, err_illegal=0, illegal_cnt=0, wrapped=0, FIFO empty, FSM=IDLE. in_ready=0 while rst_n low.
- in_ready = (fifo_count < FIFO_DEPTH) && !flush. No push/pop bypass. A bundle is accepted on a rising edge with in_valid && in_ready.
- Encoding is combinational from the inputs and captured at acceptance:
  - LOAD op 0000011: {imm[11:0], rs1, f3, rd, op}
  - OP-IMM op 0010011: {imm[11:0], rs1, f3, rd, op}
  - STORE op 0100011: {imm[11:5], rs2, rs1, f3, imm[4:0], op}
  - OP op 0110011: {funct7, rs2, rs1, f3, rd, op}
  - Fields not used by the format are ignored.
- Illegal bundles are accepted but not pushed; the next cycle has err_illegal=1 and illegal_cnt+1, saturating at 255. Illegal conditions:
  - LOAD with f3 ∈ {011, 110, 111}
  - STORE with f3 > 010
  - OP-IMM f3=001 with imm[11:5] ≠ 0000000
  - OP-IMM f3=101 with imm[11:5] ∉ {0000000, 0100000}
  - OP with funct7 ∉ {0000000, 0100000}
  - OP with funct7=0100000 and f3 ∉ {000, 101}
- Writer FSM, states IDLE and BUSY:
  - IDLE: if FIFO non-empty, pop head into mem_wdata, set mem_we=1, go to BUSY.
  - BUSY: mem_addr and mem_wdata held stable until mem_ack.
  - On mem_ack: mem_addr += 1 (modulo 2^ADDR_W). If that increment moves the address from 2^ADDR_W-1 to 0, set wrapped=1. Then, if the FIFO is non-empty, pop the next word back-to-back (mem_we stays 1, stay in BUSY); else mem_we=0 and go to IDLE.
  - mem_ack is ignored in IDLE.
- Latency: a legal bundle accepted at edge N with the FIFO empty and FSM IDLE gives mem_we=1 after edge N+1. Sustained throughput is 1 word/cycle with mem_ack tied high.
- Capacity: FIFO_DEPTH words in the FIFO plus 1 in the output register.
- Simultaneous push and pop in one cycle are both performed; count is unchanged.
- flush, on the cycle it is high:
  - empties the FIFO
  - mem_we=0 next cycle, dropping any pending write even if mem_ack is high the same cycle
  - mem_addr=BASE_ADDR, wrapped=0, FSM=IDLE
  - no bundle accepted (in_ready=0)
  - illegal_cnt is preserved
  - flush has priority over accept and ack.
- Reset asserted mid-write: outputs return to reset values immediately; the memory sees the request drop.

Test Plan:
- Single OP-IMM: rs1=0, rd=1, f3=000, imm=5, mem_ack=1 -> mem_we=1 one cycle after accept, mem_addr=0, mem_wdata=0x00500093; mem_addr=1 afterwards.
- Back-to-back LOAD (rd=2, rs1=1, f3=010, imm=8), STORE (rs1=1, rs2=2, f3=010, imm=12), OP (rd=3, rs1=1, rs2=2, f3=000, funct7=0100000), mem_ack=1 -> consecutive writes 0x0080A103 @0, 0x0020A623 @1, 0x402081B3 @2, mem_we high three consecutive cycles.
- Backpressure: mem_ack=0, FIFO_DEPTH=4, stream legal bundles -> exactly 5 accepted, then in_ready=0. mem_addr/mem_wdata stable while waiting. After releasing mem_ack, 5 writes at addr 0..4 in accept order.
- Illegal: OP with funct7=0000001, then LOAD f3=111 -> err_illegal pulses twice, illegal_cnt=2, no mem_we. A following legal bundle is written at addr 0.
- Wrap: ADDR_W=2, 5 legal bundles, mem_ack=1 -> addresses 0,1,2,3,0; wrapped=1 after the 4th ack; a subsequent flush clears wrapped and sets mem_addr=0.
- Flush mid-operation: 3 words queued, mem_ack=0, assert flush with mem_ack=1 the same cycle -> mem_we=0 next cycle, FIFO empty, no address increment, mem_addr=BASE_ADDR; the next bundle is written at addr 0.
